// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and sizing constants.
package uart_ctrl_pkg;

  // Number of byte requesters feeding the sender.
  localparam int unsigned NumReq = 2;

  // Cycles WAIT_BUSY tolerates an idle sender before re-issuing the start pulse.
  localparam int unsigned BusyTimeout = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Two-way arbiter for the UART transmit front end.
// Default: round-robin, pointer register inside, favouring req0 after reset.
// Build option UART_TX_PRIO_EN: fixed priority, req0 always beats req1.
module uart_rr_arbiter
  import uart_ctrl_pkg::*;
(
  input  logic              baudclk,
  input  logic              reset,
  input  logic [NumReq-1:0] req_valid,
  input  logic              advance,
  output logic [NumReq-1:0] gnt
);

`ifdef UART_TX_PRIO_EN
  // Fixed priority needs no history; clock, reset and advance are unused.
  logic unused_prio;
  assign unused_prio = ^{baudclk, reset, advance};

  // Requester 0 wins whenever it is valid.
  always_comb begin
    gnt = '0;
    if (req_valid[0]) begin
      gnt = 2'b01;
    end else if (req_valid[1]) begin
      gnt = 2'b10;
    end
  end
`else
  // prefer1_q set means requester 0 was served last, so requester 1 wins a tie.
  logic prefer1_q, prefer1_d;

  // Tie goes to the requester not served last; a lone valid always wins.
  always_comb begin
    gnt = '0;
    if (req_valid[0] && req_valid[1]) begin
      gnt = prefer1_q ? 2'b10 : 2'b01;
    end else if (req_valid[0]) begin
      gnt = 2'b01;
    end else if (req_valid[1]) begin
      gnt = 2'b10;
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    prefer1_d = prefer1_q;
    if (advance) begin
      prefer1_d = gnt[0];
    end
  end

  // Pointer register; reset favours requester 0.
  always_ff @(posedge baudclk or negedge reset) begin
    if (!reset) begin
      prefer1_q <= 1'b0;
    end else begin
      prefer1_q <= prefer1_d;
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte requesters onto one UART sender and sequences its start pulse.
// The sender is instantiated next to this block, not inside it.
// Build option UART_TX_PRIO_EN selects fixed priority in the arbiter; nothing else changes.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
(
  input  logic       baudclk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_status,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int unsigned TmoW = $clog2(BusyTimeout);

  tx_state_e         state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ready_q, ready_d;
  logic              tx_en_q, tx_en_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [NumReq-1:0] arb_valid, arb_gnt;
  logic              arb_advance;

  assign arb_valid = {req1_valid, req0_valid};

  uart_rr_arbiter u_arb (
    .baudclk   (baudclk),
    .reset     (reset),
    .req_valid (arb_valid),
    .advance   (arb_advance),
    .gnt       (arb_gnt)
  );

  // Next-state logic; ready and tx_en default low so each is a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    ready_d     = '0;
    tx_en_d     = 1'b0;
    tmo_d       = tmo_q;
    arb_advance = 1'b0;
    case (state_q)
      StIdle: begin
        if (tx_status && (|arb_valid)) begin
          arb_advance = 1'b1;
          grant_d     = arb_gnt;
          ready_d     = arb_gnt;
          tx_data_d   = arb_gnt[1] ? req1_data : req0_data;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        tx_en_d = 1'b1;
        tmo_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!tx_status) begin
          state_d = StWaitDone;
        end else if (tmo_q == TmoW'(BusyTimeout - 1)) begin
          // Sender never took the start pulse; issue it again with the same byte.
          state_d = StIssue;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (tx_status) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset aborts any byte in flight.
  always_ff @(posedge baudclk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tx_data_q <= 8'h00;
      grant_q   <= 2'b00;
      ready_q   <= 2'b00;
      tx_en_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      tx_en_q   <= tx_en_d;
      tmo_q     <= tmo_d;
    end
  end

  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;
  assign grant      = grant_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter paired with a behavioural 16x-oversampled UART sender and a
// line decoder. Directed vector table and corner sequences, then randomized traffic
// scored against a requester-level arbitration model.
module tb_uart_tx_arbiter;

  logic       baudclk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_data;
  logic       tx_en, tx_status, busy;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;

  always #5 baudclk = ~baudclk;

  uart_tx_arbiter dut (
    .baudclk    (baudclk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_status  (tx_status),
    .grant      (grant),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- sender model: 10-bit frame, 16 clocks per bit, data read live
  logic hold_busy  = 1'b0;  // force tx_status low
  logic lost_start = 1'b0;  // sender ignores tx_en
  logic s_busy, line;
  int   s_tick, s_idx;

  function automatic logic frame_bit(input int idx, input logic [7:0] d);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  always @(posedge baudclk or negedge reset) begin
    if (!reset) begin
      s_busy <= 1'b0; s_tick <= 0; s_idx <= 0; line <= 1'b1;
    end else if (!s_busy) begin
      if (tx_en && !lost_start) begin
        s_busy <= 1'b1; s_tick <= 0; s_idx <= 0; line <= 1'b0;
      end
    end else if (s_tick == 15) begin
      s_tick <= 0;
      if (s_idx == 9) begin
        s_busy <= 1'b0; line <= 1'b1;
      end else begin
        s_idx <= s_idx + 1;
        line  <= frame_bit(s_idx + 1, tx_data);
      end
    end else begin
      s_tick <= s_tick + 1;
    end
  end

  assign tx_status = hold_busy ? 1'b0 : !s_busy;

  // ---------------- line decoder: mid-bit sampling
  logic       rx_act;
  int         rx_cnt;
  logic [9:0] rx_frame;
  logic [9:0] last_frame = '0;
  logic [7:0] rx_q[$];

  always @(posedge baudclk or negedge reset) begin
    if (!reset) begin
      rx_act <= 1'b0; rx_cnt <= 0;
    end else if (!rx_act) begin
      if (!line) begin
        rx_act <= 1'b1; rx_cnt <= 0;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % 16 == 7) begin
        rx_frame[rx_cnt/16] <= line;
        if (rx_cnt / 16 == 9) begin
          rx_act     <= 1'b0;
          last_frame <= {line, rx_frame[8:0]};
          rx_q.push_back(rx_frame[8:1]);
        end
      end
    end
  end

  function automatic logic [31:0] rx_pop();
    if (rx_q.size() == 0) return 32'hFFFF_FFFF;
    return {24'h0, rx_q.pop_front()};
  endfunction

  // ---------------- randomized-phase reference model
  logic       mon_en = 1'b0;
  int         last_srv;
  int         mon_cnt[2];
  logic [1:0] v_prev = '0;
  logic [7:0] d0_prev, d1_prev;
  logic [7:0] exp_q[$];

  always @(negedge baudclk) begin
    if (mon_en && (req0_ready || req1_ready)) begin
      int w;
`ifdef UART_TX_PRIO_EN
      w = v_prev[0] ? 0 : 1;
`else
      w = (v_prev == 2'b11) ? 1 - last_srv : (v_prev[0] ? 0 : 1);
`endif
      chk("rnd_ready", {req1_ready, req0_ready}, 32'(1) << w);
      chk("rnd_grant", grant, 32'(1) << w);
      chk("rnd_data", tx_data, (w == 0) ? d0_prev : d1_prev);
      chk("rnd_valid_before", v_prev[w], 1);
      last_srv = w;
      mon_cnt[w]++;
      exp_q.push_back((w == 0) ? d0_prev : d1_prev);
    end
    v_prev  = {req1_valid, req0_valid};
    d0_prev = req0_data;
    d1_prev = req1_data;
  end

  // ---------------- helpers
  task automatic cyc(input int n);
    repeat (n) @(negedge baudclk);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; hold_busy = 1'b0; lost_start = 1'b0;
    @(negedge baudclk);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    rx_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge baudclk);
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic drive(input int idx, input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      int  n;
      logic got;
      repeat ($urandom_range(0, 12)) @(posedge baudclk);
      #1;
      if (idx == 0) begin req0_data = 8'($urandom); req0_valid = 1'b1; end
      else          begin req1_data = 8'($urandom); req1_valid = 1'b1; end
      n = 0; got = 1'b0;
      while (!got && n < 2000) begin
        @(negedge baudclk);
        n++;
        got = (idx == 0) ? req0_ready : req1_ready;
      end
      chk($sformatf("rnd_accept%0d", idx), got, 1);
      @(posedge baudclk);
      #1;
      if (idx == 0) req0_valid = 1'b0;
      else          req1_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic [1:0] g;
    logic [7:0] d;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int         bad, n, c0, c1, gap_bad;
    logic       prev_avail;
    logic [1:0] gseq[$];
    logic [7:0] cexp[8];

    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    cyc(2);

    // Reset state
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant", grant, 2'b00);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    cyc(1);

    // Single byte 8'hA5 from req0
    req0_data = 8'hA5; req0_valid = 1'b1;
    @(negedge baudclk);
    chk("sb_ready", {req1_ready, req0_ready}, 2'b01);
    chk("sb_tx_en_early", tx_en, 0);
    chk("sb_grant", grant, 2'b01);
    chk("sb_tx_data", tx_data, 8'hA5);
    req0_valid = 1'b0;
    @(negedge baudclk);
    chk("sb_tx_en", tx_en, 1);
    chk("sb_ready_once", {req1_ready, req0_ready}, 2'b00);
    bad = 0; n = 0;
    while (busy && n < 400) begin
      if (grant !== 2'b01 || tx_data !== 8'hA5) bad++;
      @(negedge baudclk);
      n++;
    end
    chk("sb_hold", bad, 0);
    chk("sb_idle", busy, 0);
    chk("sb_grant_clr", grant, 2'b00);
    chk("sb_frame", last_frame, 10'b11_0100_1010);
    chk("sb_rx", rx_pop(), 8'hA5);

    // Vector table: one arbitration per row, pointer history carried row to row
    tbl[0] = '{1'b1, 1'b1, 8'h11, 8'h22, 2'b01, 8'h11};
    tbl[1] = '{1'b1, 1'b1, 8'h13, 8'h24, 2'b10, 8'h24};
    tbl[2] = '{1'b1, 1'b0, 8'h33, 8'h00, 2'b01, 8'h33};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h44, 2'b10, 8'h44};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h55, 2'b10, 8'h55};
    tbl[5] = '{1'b1, 1'b1, 8'h66, 8'h77, 2'b01, 8'h66};
    tbl[6] = '{1'b1, 1'b1, 8'h68, 8'h79, 2'b10, 8'h79};
`ifdef UART_TX_PRIO_EN
    for (int i = 0; i < 7; i++) begin
      tbl[i].g = tbl[i].v0 ? 2'b01 : 2'b10;
      tbl[i].d = tbl[i].v0 ? tbl[i].d0 : tbl[i].d1;
    end
`endif
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_data  = tbl[i].d0; req1_data  = tbl[i].d1;
      @(negedge baudclk);
      chk($sformatf("tbl%0d_ready", i), {req1_ready, req0_ready}, tbl[i].g);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].d);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge baudclk);
      chk($sformatf("tbl%0d_tx_en", i), tx_en, 1);
      wait_idle($sformatf("tbl%0d_idle", i));
      chk($sformatf("tbl%0d_grant_clr", i), grant, 2'b00);
      chk($sformatf("tbl%0d_rx", i), rx_pop(), tbl[i].d);
    end

    // Contention: both requesters hold four bytes each, back to back
    do_reset();
    req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
    c0 = 0; c1 = 0; n = 0; gap_bad = 0; prev_avail = 1'b1;
    while ((c0 < 4 || c1 < 4) && n < 3000) begin
      @(negedge baudclk);
      n++;
      if (prev_avail && !(req0_ready || req1_ready)) gap_bad++;
      if (req0_ready) begin c0++; gseq.push_back(grant); end
      if (req1_ready) begin c1++; gseq.push_back(grant); end
      if (c0 == 4) req0_valid = 1'b0;
      if (c1 == 4) req1_valid = 1'b0;
      prev_avail = !busy && tx_status && (req0_valid || req1_valid);
    end
    chk("cont_cnt0", c0, 4);
    chk("cont_cnt1", c1, 4);
    chk("cont_b2b", gap_bad, 0);
    wait_idle("cont_idle");
    for (int i = 0; i < 8; i++) begin
`ifdef UART_TX_PRIO_EN
      cexp[i] = (i < 4) ? 8'h11 : 8'h22;
`else
      cexp[i] = (i % 2 == 0) ? 8'h11 : 8'h22;
`endif
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cont_rx%0d", i), rx_pop(), cexp[i]);
      chk($sformatf("cont_grant%0d", i), (gseq.size() > 0) ? gseq.pop_front() : 2'b00,
          (cexp[i] == 8'h11) ? 2'b01 : 2'b10);
    end

    // Sender held busy: no acceptance until tx_status rises
    hold_busy = 1'b1; req1_data = 8'h5A; req1_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge baudclk);
      if (req1_ready) bad++;
    end
    chk("hb_no_ready", bad, 0);
    chk("hb_busy", busy, 0);
    hold_busy = 1'b0;
    @(negedge baudclk);
    chk("hb_ready", req1_ready, 1);
    req1_valid = 1'b0;
    wait_idle("hb_idle");
    chk("hb_rx", rx_pop(), 8'h5A);

    // Lost start: sender never goes busy, start pulse must repeat with data unchanged
    lost_start = 1'b1; req0_data = 8'hC3; req0_valid = 1'b1;
    @(negedge baudclk);
    chk("ls_ready", req0_ready, 1);
    req0_valid = 1'b0; req0_data = 8'h00;
    @(negedge baudclk);
    chk("ls_tx_en0", tx_en, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge baudclk);
      chk($sformatf("ls_tx_en%0d", k), tx_en, (k == 5) ? 1 : 0);
      chk($sformatf("ls_data%0d", k), tx_data, 8'hC3);
    end
    lost_start = 1'b0;
    wait_idle("ls_idle");
    chk("ls_rx", rx_pop(), 8'hC3);

    // Mid-frame abort: reset 40 cycles after tx_en
    req1_data = 8'h3C; req1_valid = 1'b1;
    @(negedge baudclk);
    chk("ab_ready", req1_ready, 1);
    req1_valid = 1'b0;
    @(negedge baudclk);
    chk("ab_tx_en", tx_en, 1);
    cyc(40);
    reset = 1'b0;
    #1;
    chk("ab_tx_en_clr", tx_en, 0);
    chk("ab_grant_clr", grant, 2'b00);
    chk("ab_busy_clr", busy, 0);
    chk("ab_ready_clr", {req1_ready, req0_ready}, 2'b00);
    @(negedge baudclk);
    reset = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge baudclk);
      if (req0_ready || req1_ready || tx_en || busy) bad++;
    end
    chk("ab_quiet", bad, 0);
    req0_data = 8'h77; req0_valid = 1'b1;
    @(negedge baudclk);
    chk("ab_rearb", req0_ready, 1);
    req0_valid = 1'b0;
    wait_idle("ab_idle");
    chk("ab_rx", rx_pop(), 8'h77);
    chk("ab_rx_empty", rx_q.size(), 0);

    // Randomized traffic against the arbitration model
    do_reset();
    last_srv = 1;
    mon_cnt[0] = 0; mon_cnt[1] = 0;
    exp_q.delete();
    mon_en = 1'b1;
    fork
      drive(0, 12);
      drive(1, 12);
    join
    wait_idle("rnd_idle");
    mon_en = 1'b0;
    chk("rnd_cnt0", mon_cnt[0], 12);
    chk("rnd_cnt1", mon_cnt[1], 12);
    chk("rnd_len", rx_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      chk("rnd_rx", rx_pop(), exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL use clock baudclk and reset reset, asynchronous, active-low.
REQ-002 Ports SHALL be (name direction width meaning):
  baudclk  in  1  16x baud clock, shared with the UART sender
  reset  in  1  async active-low reset
  req0_valid  in  1  requester 0 has a byte
  req0_data  in  8  requester 0 byte, held while req0_valid=1 and req0_ready=0
  req0_ready  out  1  one-cycle pulse; byte 0 accepted
  req1_valid  in  1  requester 1 has a byte
  req1_data  in  8  requester 1 byte, same hold rule
  req1_ready  out  1  one-cycle pulse; byte 1 accepted
  tx_data  out  8  byte to sender, registered
  tx_en  out  1  start pulse to sender
  tx_status  in  1  sender idle (1) / busy (0)
  grant  out  2  one-hot owner of the current byte; 00 when idle
  busy  out  1  high in every state except IDLE

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-004 IDLE SHALL arbitrate only when tx_status=1 and at least one valid is high; otherwise it SHALL stay in IDLE.
REQ-005 On arbitration the block SHALL do three things on the same edge:
  - latch the winner's data into tx_data;
  - set grant;
  - pulse that requester's ready for exactly one cycle and enter ISSUE.
REQ-006 Arbitration SHALL be round-robin:
  - the requester not served last wins when both valids are high;
  - a lone valid wins unconditionally.
REQ-007 ISSUE SHALL drive tx_en=1 for exactly one cycle, then enter WAIT_BUSY.
REQ-008 WAIT_BUSY SHALL enter WAIT_DONE on the first cycle tx_status=0.
REQ-009 WAIT_BUSY SHALL re-enter ISSUE if tx_status stays 1 for 4 cycles, re-pulsing tx_en.
REQ-010 WAIT_DONE SHALL return to IDLE when tx_status=1, and clear grant on that edge.
REQ-011 tx_data SHALL remain constant from ISSUE until the return to IDLE, because the sender samples data live.
REQ-012 Latency from valid in IDLE (sender idle) to ready SHALL be 1 cycle; tx_en SHALL follow 1 cycle later.
REQ-013 Valid changes outside IDLE SHALL be ignored; only one ready pulse SHALL occur per byte.
REQ-014 Back-to-back bytes SHALL be supported; the next arbitration SHALL occur in the first IDLE cycle with tx_status=1.

Reset
REQ-015 Reset SHALL force the following: state IDLE, tx_en=0, tx_data=8'h00, grant=00, req0_ready=0, req1_ready=0, busy=0, and the round-robin pointer set to favour req0.
REQ-016 Reset asserted mid-byte SHALL abort immediately, with no ready or tx_en pulse after release until new arbitration.

Configuration
REQ-017 With UART_TX_PRIO_EN defined, arbitration SHALL be fixed priority, req0 always beating req1.
REQ-018 Without UART_TX_PRIO_EN, arbitration SHALL be round-robin as in REQ-006.
REQ-019 UART_TX_PRIO_EN SHALL NOT change any other behaviour.

Structure
REQ-020 Package uart_ctrl_pkg SHALL hold the following:
  - FSM state encoding (2-bit);
  - requester count constant (2);
  - WAIT_BUSY timeout constant (4).
REQ-021 Arbitration SHALL be one sub-module, uart_rr_arbiter (2-way, pointer register inside).
REQ-022 uart_tx_arbiter SHALL NOT instantiate the sender; both are instantiated side by side at top level.

Verification
REQ-023 The bench SHALL pair the block with the real sender and check the serial line. Directed scenarios:
  - Single byte: req0 sends 8'hA5 with req1 idle -> req0_ready one cycle later; tx_en the next cycle; grant=01 until tx_status returns high; line frame is 0,1,0,1,0,0,1,0,1,1 LSB-first.
  - Contention: both valid at once, req0=8'h11, req1=8'h22, repeated 4 bytes each -> serial order 11,22,11,22,... and grant alternates.
  - Same contention with UART_TX_PRIO_EN -> all four 8'h11 bytes before any 8'h22.
  - Mid-frame abort: reset pulsed 40 cycles after tx_en -> tx_en=0, grant=00, busy=0 immediately; no ready pulse until new arbitration.
  - Sender held busy: tx_status forced 0 while req1_valid=1 -> no req1_ready until tx_status=1.
  - Lost start: tx_status never falls after tx_en -> tx_en re-pulsed after 4 cycles, with tx_data unchanged.
